// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared definitions for the arbitrated memory block
package mem_arbiter_pkg;

    localparam int BIT_DATA   = 16;
    localparam int SZB_RAM    = 8;
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin / fixed-priority single-grant arbiter
module rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int MODE = MODE_RR,
    parameter int PW   = clog2_min1(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;

    // Search starts at the pointer in round-robin mode, at channel 0 otherwise.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (MODE == MODE_FIXED) begin
                cand = PW'(i);
            end else begin
                cand = PW'((int'(ptr) + i) % N_CH);
            end
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (!rst_n) begin
            gnt_any = 1'b0;
            gnt_idx = '0;
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (MODE == MODE_RR && gnt_any) begin
            ptr <= (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - multi-channel arbitrated single-port memory with tagged read pipeline
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int BIT    = BIT_DATA,
    parameter int SZB    = SZB_RAM,
    parameter int RD_LAT = 1,
    parameter int MODE   = MODE_RR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     req,
    input  logic [N_CH-1:0]     we,
    input  logic [N_CH*SZB-1:0] addr,
    input  logic [N_CH*BIT-1:0] d,
    output logic [N_CH-1:0]     gnt,
    output logic [BIT-1:0]      q,
    output logic [N_CH-1:0]     q_valid
);

    localparam int PW = clog2_min1(N_CH);

    logic [PW-1:0]  gnt_idx;
    logic           gnt_any;
    logic [SZB-1:0] sel_addr;
    logic [BIT-1:0] sel_d;
    logic           sel_we;
    logic           rd_go;

    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE),
        .PW   (PW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign sel_addr = addr[int'(gnt_idx)*SZB +: SZB];
    assign sel_d    = d[int'(gnt_idx)*BIT +: BIT];
    assign sel_we   = we[gnt_idx];
    assign rd_go    = gnt_any && !sel_we;

    // Memory is deliberately left out of reset so contents survive it.
    logic [BIT-1:0] mem [2**SZB];

    always_ff @(posedge clk) begin
        if (gnt_any && sel_we) begin
            mem[sel_addr] <= sel_d;
        end
    end

    logic           pv    [RD_LAT];
    logic [PW-1:0]  ptag  [RD_LAT];
    logic [BIT-1:0] pdata [RD_LAT];

    // Data stages only load on a valid entry, so the last stage holds q between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pv[s]    <= 1'b0;
                ptag[s]  <= '0;
                pdata[s] <= '0;
            end
        end else begin
            pv[0] <= rd_go;
            if (rd_go) begin
                ptag[0]  <= gnt_idx;
                pdata[0] <= mem[sel_addr];
            end
            for (int s = 1; s < RD_LAT; s++) begin
                pv[s] <= pv[s-1];
                if (pv[s-1]) begin
                    ptag[s]  <= ptag[s-1];
                    pdata[s] <= pdata[s-1];
                end
            end
        end
    end

    assign q = pdata[RD_LAT-1];

    always_comb begin
        q_valid = '0;
        if (pv[RD_LAT-1]) begin
            q_valid[ptag[RD_LAT-1]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (RR/lat1 and fixed/lat2 instances)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  we = '0;
    logic [31:0] addr = '0;
    logic [63:0] d = '0;
    logic [3:0]  gnt_a, qv_a, gnt_b, qv_b;
    logic [15:0] q_a, q_b;

    always #5 clk = ~clk;

    mem_arbiter #(.N_CH(4), .BIT(16), .SZB(8), .RD_LAT(1), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .d(d),
        .gnt(gnt_a), .q(q_a), .q_valid(qv_a)
    );

    mem_arbiter #(.N_CH(4), .BIT(16), .SZB(8), .RD_LAT(2), .MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .d(d),
        .gnt(gnt_b), .q(q_b), .q_valid(qv_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk(act === exp, name, act, exp);
    endtask

    // Model: instance 0 is round-robin with latency 1, instance 1 fixed priority with latency 2.
    int          ptr_m   [2];
    logic [15:0] mem_m   [2][256];
    bit          known_m [2][256];
    bit          sv      [2][4];
    int          sch     [2][4];
    logic [15:0] sd      [2][4];
    bit          sk      [2][4];
    logic [15:0] lq      [2];
    bit          lk      [2];
    int          wait_a  [4];

    function automatic logic [3:0] exp_gnt(input int k, input logic [3:0] r);
        int c;
        for (int j = 0; j < 4; j++) begin
            c = (k == 0) ? (ptr_m[k] + j) % 4 : j;
            if (r[c]) return 4'b0001 << c;
        end
        return 4'b0000;
    endfunction

    task automatic model_step(input int k, input logic [3:0] g, input logic [15:0] qq, input logic [3:0] qv);
        logic [3:0] eg;
        int s, s2, c, a;
        string pfx;
        pfx = (k == 0) ? "a" : "b";
        eg = exp_gnt(k, req);
        chk(g === eg, {pfx, "_gnt"}, g, eg);
        s = cyc % 4;
        if (sv[k][s]) begin
            chk(qv === (4'b0001 << sch[k][s]), {pfx, "_q_valid"}, qv, 4'b0001 << sch[k][s]);
            if (sk[k][s]) chk(qq === sd[k][s], {pfx, "_q_data"}, qq, sd[k][s]);
            lq[k] = sd[k][s];
            lk[k] = sk[k][s];
            sv[k][s] = 1'b0;
        end else begin
            chk(qv === 4'b0000, {pfx, "_q_valid_idle"}, qv, 0);
            if (lk[k]) chk(qq === lq[k], {pfx, "_q_hold"}, qq, lq[k]);
        end
        if (eg != 4'b0000) begin
            c = $clog2(eg);
            a = int'(addr[c*8 +: 8]);
            if (we[c]) begin
                mem_m[k][a] = d[c*16 +: 16];
                known_m[k][a] = 1'b1;
            end else begin
                s2 = (cyc + k + 1) % 4;
                sv[k][s2] = 1'b1;
                sch[k][s2] = c;
                sd[k][s2] = mem_m[k][a];
                sk[k][s2] = known_m[k][a];
            end
            if (k == 0) ptr_m[0] = (c + 1) % 4;
        end
        if (k == 0) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (req[ch] && !g[ch]) wait_a[ch]++;
                else wait_a[ch] = 0;
                if (req[ch]) chk(wait_a[ch] <= 3, "a_wait_bound", wait_a[ch], 3);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ptr_m[k] = 0;
                lq[k] = '0;
                lk[k] = 1'b1;
                for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
            end
            for (int ch = 0; ch < 4; ch++) wait_a[ch] = 0;
            chk(gnt_a === 4'b0 && gnt_b === 4'b0, "rst_gnt", {gnt_a, gnt_b}, 0);
            chk(qv_a === 4'b0 && qv_b === 4'b0, "rst_q_valid", {qv_a, qv_b}, 0);
            chk(q_a === 16'h0 && q_b === 16'h0, "rst_q", {q_a, q_b}, 0);
        end else begin
            model_step(0, gnt_a, q_a, qv_a);
            model_step(1, gnt_b, q_b, qv_b);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setch(input int c, input bit r, input bit w, input logic [7:0] ad, input logic [15:0] dd);
        req[c] = r;
        we[c] = w;
        addr[c*8 +: 8] = ad;
        d[c*16 +: 16] = dd;
    endtask

    logic [3:0] g_seen;

    initial begin
        req = 4'hF;
        repeat (3) step();
        @(negedge clk);
        lit("rst_gnt_forced", gnt_a, 4'b0000);
        lit("rst_q_zero", q_a, 16'h0000);

        // ch0 writes 0xA5A5 to 0x10, then ch1 reads it back
        step(); rst_n = 1'b1; req = '0; we = '0;
        setch(0, 1, 1, 8'h10, 16'hA5A5);
        @(negedge clk); lit("wr_gnt_a", gnt_a, 4'b0001); lit("wr_gnt_b", gnt_b, 4'b0001);
        step(); req = '0; we = '0; setch(1, 1, 0, 8'h10, 16'h0000);
        @(negedge clk); lit("rd_gnt_a", gnt_a, 4'b0010); lit("rd_gnt_b", gnt_b, 4'b0010);
        step(); req = '0;
        @(negedge clk); lit("rd_qv_a", qv_a, 4'b0010); lit("rd_q_a", q_a, 16'hA5A5);
        lit("rd_qv_b_early", qv_b, 4'b0000);
        step();
        @(negedge clk); lit("rd_qv_b", qv_b, 4'b0010); lit("rd_q_b", q_b, 16'hA5A5);
        lit("hold_q_a", q_a, 16'hA5A5); lit("hold_qv_a", qv_a, 4'b0000);

        // all channels requesting after reset: rotation 1,2,4,8
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1; req = 4'hF; we = '0; addr = {4{8'h10}};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lit("rr_seq_a", gnt_a, 4'b0001 << (i % 4));
            lit("fixed_all_b", gnt_b, 4'b0001);
            step();
        end

        req = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit("fixed_1110_b", gnt_b, 4'b0010);
            step();
        end

        // back-to-back reads of 0x01 / 0x02
        req = '0; we = '0; setch(0, 1, 1, 8'h01, 16'h1111);
        @(negedge clk); step();
        req = '0; we = '0; setch(1, 1, 1, 8'h02, 16'h2222);
        @(negedge clk); step();
        req = '0; we = '0; setch(0, 1, 0, 8'h01, 16'h0000);
        @(negedge clk); step();
        req = '0; setch(1, 1, 0, 8'h02, 16'h0000);
        @(negedge clk); lit("b2b_qv_a0", qv_a, 4'b0001); lit("b2b_q_a0", q_a, 16'h1111);
        step(); req = '0;
        @(negedge clk); lit("b2b_qv_b0", qv_b, 4'b0001); lit("b2b_q_b0", q_b, 16'h1111);
        lit("b2b_qv_a1", qv_a, 4'b0010); lit("b2b_q_a1", q_a, 16'h2222);
        step();
        @(negedge clk); lit("b2b_qv_b1", qv_b, 4'b0010); lit("b2b_q_b1", q_b, 16'h2222);

        // reset one cycle after a read grant discards it
        step(); req = '0; we = '0; setch(2, 1, 0, 8'h01, 16'h0000);
        @(negedge clk); lit("pre_rst_gnt_a", gnt_a, 4'b0100);
        step(); rst_n = 1'b0; req = '0;
        @(negedge clk); lit("inrst_qv_a", qv_a, 4'b0000); lit("inrst_q_a", q_a, 16'h0000);
        step();
        @(negedge clk); lit("inrst_qv_b", qv_b, 4'b0000); lit("inrst_q_b", q_b, 16'h0000);
        step(); rst_n = 1'b1; req = 4'hF; we = '0; addr = {4{8'h10}};
        @(negedge clk); lit("post_rst_gnt_a", gnt_a, 4'b0001); lit("post_rst_gnt_b", gnt_b, 4'b0001);
        lit("post_rst_qv_a", qv_a, 4'b0000); lit("post_rst_qv_b", qv_b, 4'b0000);
        step(); req = '0;
        @(negedge clk); lit("keep_qv_a", qv_a, 4'b0001); lit("keep_q_a", q_a, 16'hA5A5);
        step();
        @(negedge clk); lit("keep_qv_b", qv_b, 4'b0001); lit("keep_q_b", q_b, 16'hA5A5);

        // random traffic; each channel holds its request until instance a grants it
        step(); req = '0; we = '0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            g_seen = gnt_a;
            step();
            for (int ch = 0; ch < 4; ch++) begin
                if (!req[ch] || g_seen[ch]) begin
                    setch(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 31)), 16'($urandom));
                end
            end
        end
        req = '0;
        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

endmodule
